core_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences fetch -> exec -> mem -> writeback over one shared memory bus.

---
 rtl/core_pkg.sv | 52 +++++
 rtl/core_bus_watchdog.sv | 31 +++
 rtl/core_sequencer.sv | 139 +++++++++++++
 tb/tb_core_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I multi-cycle core.
// Sequencer states, PC/writeback selectors, trap causes and small decode helpers.
package core_pkg;

    typedef enum logic [2:0] {
        RESET, FETCH, EXEC, MEM, WB, TRAP, HALT
    } seq_state_e;

    typedef enum logic [1:0] {
        PC_SEL_SEQ, PC_SEL_TARGET, PC_SEL_TRAP
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_NONE, WB_ALU, WB_MEM, WB_PC4
    } wb_src_e;

    typedef enum logic [1:0] {
        PC_PLUS4, PC_BRANCH, PC_JUMP
    } pc_src_e;

    localparam logic       MEM_READ   = 1'b0;
    localparam logic       MEM_WRITE  = 1'b1;
    localparam logic [2:0] MEM_SIZE_W = 3'd2;

    localparam logic [3:0] CAUSE_FETCH_FAULT    = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size[1:0] == 2'd1) begin
            mis = addr_lo[0];
        end else if (size[1:0] == 2'd2) begin
            mis = (addr_lo != 2'd0);
        end
        return mis;
    endfunction

    function automatic pc_sel_e wb_pc_sel(input pc_src_e src, input logic taken);
        pc_sel_e sel;
        sel = PC_SEL_SEQ;
        if (src == PC_JUMP || (src == PC_BRANCH && taken)) begin
            sel = PC_SEL_TARGET;
        end
        return sel;
    endfunction

endpackage

// File: rtl/core_bus_watchdog.sv
// Bus watchdog: flags an access that has waited TIMEOUT cycles without an ack.
// TIMEOUT of 0 disables it; an ack in the limit cycle suppresses expiry.
module core_bus_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q;

    // cnt_q holds the number of earlier waiting cycles, so the limit is hit at LAST.
    assign expired = (TIMEOUT != 0) && active && !ack && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (active && !ack && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch -> exec -> mem -> writeback over one shared bus,
// with trap handling, debug halt and the cycle/instret counters.
module core_sequencer
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_mem_op,
    input  logic             dec_mem_dir,
    input  logic [2:0]       dec_mem_size,
    input  wb_src_e          dec_wb_src,
    input  pc_src_e          dec_pc_src,
    input  logic             dec_illegal,
    input  logic             br_taken,
    input  logic [1:0]       addr_lo,
    input  logic             halt_req,
    output logic             bus_req,
    output logic             bus_we,
    output logic [2:0]       bus_size,
    output logic             bus_addr_sel,
    input  logic             bus_ack,
    input  logic             bus_err,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output pc_sel_e          pc_sel,
    output logic             trap,
    output logic [3:0]       trap_cause,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    seq_state_e state_q, state_d;
    logic [3:0] cause_d;
    logic       ack_v;
    logic       wd_expired;

    assign ack_v = bus_req && bus_ack;
    assign ir_we = (state_q == FETCH) && ack_v && !bus_err;

    core_bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (bus_req),
        .ack    (bus_ack),
        .expired(wd_expired)
    );

    always_comb begin
        state_d = state_q;
        cause_d = 4'd0;
        case (state_q)
            RESET: state_d = FETCH;
            FETCH: begin
                if ((ack_v && bus_err) || (!ack_v && wd_expired)) begin
                    state_d = TRAP;
                    cause_d = CAUSE_FETCH_FAULT;
                end else if (ack_v) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (dec_illegal) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_mem_op && is_misaligned(dec_mem_size, addr_lo)) begin
                    state_d = TRAP;
                    cause_d = dec_mem_dir ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
                end else if (dec_mem_op) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if ((ack_v && bus_err) || (!ack_v && wd_expired)) begin
                    state_d = TRAP;
                    cause_d = dec_mem_dir ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                end else if (ack_v) begin
                    state_d = WB;
                end
            end
            WB, TRAP: state_d = halt_req ? HALT : FETCH;
            HALT: begin
                if (!halt_req) begin
                    state_d = FETCH;
                end
            end
            default: state_d = RESET;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free for the whole state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_size     <= 3'd0;
            bus_addr_sel <= 1'b0;
            rf_we        <= 1'b0;
            pc_we        <= 1'b0;
            pc_sel       <= PC_SEL_SEQ;
            trap         <= 1'b0;
            trap_cause   <= 4'd0;
            halted       <= 1'b0;
            retire       <= 1'b0;
            cycle_cnt    <= '0;
            instret_cnt  <= '0;
        end else begin
            state_q      <= state_d;
            bus_req      <= (state_d == FETCH) || (state_d == MEM);
            bus_we       <= (state_d == MEM) && dec_mem_dir;
            bus_size     <= (state_d == MEM) ? dec_mem_size :
                            (state_d == FETCH) ? MEM_SIZE_W : 3'd0;
            bus_addr_sel <= (state_d == MEM);
            rf_we        <= (state_d == WB) && (dec_wb_src != WB_NONE);
            pc_we        <= (state_d == WB) || (state_d == TRAP);
            pc_sel       <= (state_d == TRAP) ? PC_SEL_TRAP :
                            (state_d == WB) ? wb_pc_sel(dec_pc_src, br_taken) : PC_SEL_SEQ;
            trap         <= (state_d == TRAP);
            trap_cause   <= cause_d;
            halted       <= (state_d == HALT);
            retire       <= (state_d == WB);
            cycle_cnt    <= cycle_cnt + CNT_W'(1);
            if (state_q == WB) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed cases then randomized instruction
// streams checked cycle by cycle against an instruction-level reference model.
module tb_core_sequencer;
    import core_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_mem_op = 1'b0, dec_mem_dir = 1'b0, dec_illegal = 1'b0;
    logic [2:0]  dec_mem_size = 3'd0;
    wb_src_e     dec_wb_src = WB_NONE;
    pc_src_e     dec_pc_src = PC_PLUS4;
    logic        br_taken = 1'b0, halt_req = 1'b0, bus_ack = 1'b0, bus_err = 1'b0;
    logic [1:0]  addr_lo = 2'd0;
    logic        bus_req, bus_we, bus_addr_sel, ir_we, rf_we, pc_we, trap, halted, retire;
    logic [2:0]  bus_size;
    logic [3:0]  trap_cause;
    pc_sel_e     pc_sel;
    logic [63:0] cycle_cnt, instret_cnt;

    int          total = 0;
    int          bad = 0;
    longint      exp_cycle = 0;
    longint      exp_instret = 0;

    always #5 clk = ~clk;

    core_sequencer #(.TIMEOUT(TO), .CNT_W(64)) dut (
        .clk(clk), .rst(rst),
        .dec_mem_op(dec_mem_op), .dec_mem_dir(dec_mem_dir), .dec_mem_size(dec_mem_size),
        .dec_wb_src(dec_wb_src), .dec_pc_src(dec_pc_src), .dec_illegal(dec_illegal),
        .br_taken(br_taken), .addr_lo(addr_lo), .halt_req(halt_req),
        .bus_req(bus_req), .bus_we(bus_we), .bus_size(bus_size), .bus_addr_sel(bus_addr_sel),
        .bus_ack(bus_ack), .bus_err(bus_err), .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause), .halted(halted),
        .retire(retire), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        exp_cycle++;
    endtask

    // Acks outside a request must be ignored, so idle cycles carry random noise.
    task automatic junk_ack();
        bus_ack = 1'($urandom_range(0, 1));
        bus_err = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        bus_ack  = 1'b0;
        halt_req = 1'b0;
        rst      = 1'b1;
        #1;
        check_eq("rst_bus_req", bus_req, 0);
        check_eq("rst_cycle", cycle_cnt, 0);
        check_eq("rst_instret", instret_cnt, 0);
        check_eq("rst_outs", {halted, trap, retire, pc_we, rf_we, ir_we}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cycle   = 0;
        exp_instret = 0;
        @(negedge clk);
        check_eq("reset_state_req", bus_req, 0);
        check_eq("reset_state_cycle", cycle_cnt, 0);
        adv();
    endtask

    task automatic bus_phase(input bit is_fetch, input bit dir, input logic [2:0] sz,
                             input int wait_n, input bit err, output bit fault);
        fault = 1'b1;
        for (int i = 0; i < int'(TO); i++) begin
            bus_ack = (i == wait_n);
            bus_err = (i == wait_n) ? err : 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq(is_fetch ? "f_req" : "m_req", bus_req, 1);
            check_eq(is_fetch ? "f_sel" : "m_sel", bus_addr_sel, !is_fetch);
            check_eq(is_fetch ? "f_we" : "m_we", bus_we, is_fetch ? 1'b0 : dir);
            check_eq(is_fetch ? "f_size" : "m_size", bus_size, sz);
            check_eq("ir_we", ir_we, is_fetch && (i == wait_n) && !err);
            check_eq("bus_halted", halted, 0);
            adv();
            if (i == wait_n) begin
                fault = err;
                return;
            end
        end
    endtask

    task automatic end_cycle(input bit is_trap, input logic [3:0] cause, input bit rf,
                             input logic [1:0] sel);
        junk_ack();
        @(negedge clk);
        check_eq("trap", trap, is_trap);
        if (is_trap) check_eq("trap_cause", trap_cause, cause);
        check_eq("pc_we", pc_we, 1);
        check_eq("pc_sel", pc_sel, sel);
        check_eq("retire", retire, !is_trap);
        check_eq("rf_we", rf_we, rf);
        check_eq("end_req", bus_req, 0);
        check_eq("instret", instret_cnt, exp_instret);
        check_eq("cycle_cnt", cycle_cnt, exp_cycle);
        if (!is_trap) exp_instret++;
        adv();
    endtask

    task automatic do_instr(input bit ill, input bit mem, input bit dir, input logic [2:0] sz,
                            input logic [1:0] alo, input logic [1:0] wbs, input logic [1:0] pcs,
                            input bit br, input int fw, input bit ferr, input int mw,
                            input bit merr, input bit hlt, input int hcyc);
        bit         fault;
        int         bytes;
        logic [3:0] cause;
        dec_illegal  = ill;
        dec_mem_op   = mem;
        dec_mem_dir  = dir;
        dec_mem_size = sz;
        addr_lo      = alo;
        dec_wb_src   = wb_src_e'(wbs);
        dec_pc_src   = pc_src_e'(pcs);
        br_taken     = br;
        halt_req     = hlt;
        cause        = 4'd0;
        bus_phase(1'b1, 1'b0, 3'd2, fw, ferr, fault);
        if (fault) begin
            cause = 4'd1;
        end else begin
            junk_ack();
            @(negedge clk);
            check_eq("exec_req", bus_req, 0);
            check_eq("exec_outs", {trap, retire, pc_we, ir_we}, 0);
            adv();
            bytes = 1 << sz[1:0];
            if (ill) cause = 4'd2;
            else if (mem && (int'(alo) % bytes) != 0) cause = dir ? 4'd6 : 4'd4;
            else if (mem) begin
                bus_phase(1'b0, dir, sz, mw, merr, fault);
                if (fault) cause = dir ? 4'd7 : 4'd5;
            end
        end
        if (cause != 0) end_cycle(1'b1, cause, 1'b0, 2'd2);
        else end_cycle(1'b0, 4'd0, wbs != 2'd0, (pcs == 2'd2 || (pcs == 2'd1 && br)) ? 2'd1 : 2'd0);
        if (hlt) begin
            for (int k = 0; k < hcyc; k++) begin
                junk_ack();
                @(negedge clk);
                check_eq("halted", halted, 1);
                check_eq("halt_req_out", bus_req, 0);
                adv();
            end
            halt_req = 1'b0;
            junk_ack();
            @(negedge clk);
            check_eq("halt_last", halted, 1);
            check_eq("halt_last_req", bus_req, 0);
            adv();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int fw;
        int mw;
        #2;
        do_reset();
        // ill mem dir sz alo wb pc br fw ferr mw merr hlt hc
        do_instr(0, 0, 0, 3'd2, 2'd0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);      // addi
        do_instr(0, 1, 0, 3'd2, 2'd0, 2'd2, 2'd0, 0, 0, 0, 2, 0, 0, 0);      // lw, 2 waits
        do_instr(0, 1, 1, 3'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);      // sh misaligned
        do_instr(0, 0, 0, 3'd0, 2'd0, 2'd0, 2'd1, 1, 0, 0, 0, 0, 0, 0);      // beq taken
        do_instr(0, 0, 0, 3'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0);      // bne not taken
        do_instr(0, 0, 0, 3'd2, 2'd0, 2'd1, 2'd0, 0, 99, 0, 0, 0, 0, 0);     // fetch timeout
        do_instr(0, 0, 0, 3'd2, 2'd0, 2'd3, 2'd2, 0, TO - 1, 0, 0, 0, 0, 0); // ack at limit
        do_instr(0, 1, 1, 3'd2, 2'd0, 2'd0, 2'd0, 0, 0, 0, 99, 0, 0, 0);     // store timeout
        do_instr(0, 1, 0, 3'd0, 2'd3, 2'd2, 2'd0, 0, 0, 0, 1, 1, 0, 0);      // load fault
        do_instr(0, 0, 0, 3'd2, 2'd0, 2'd1, 2'd0, 0, 1, 1, 0, 0, 0, 0);      // fetch fault
        do_instr(1, 1, 0, 3'd2, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);      // illegal wins
        do_instr(0, 1, 0, 3'd2, 2'd2, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0);      // lw misaligned
        do_instr(0, 1, 0, 3'd2, 2'd0, 2'd2, 2'd0, 0, 0, 0, 1, 0, 1, 2);      // lw then halt
        do_instr(0, 0, 0, 3'd2, 2'd0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);

        // reset pulsed mid-FETCH drops the request asynchronously
        bus_ack = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_req", bus_req, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_drop", bus_req, 0);
        do_reset();

        for (int n = 0; n < 250; n++) begin
            fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO + 3))
                                             : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO + 3))
                                             : int'($urandom_range(0, 2));
            do_instr($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     fw, $urandom_range(0, 9) == 0, mw, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
